fp_to_int_seq: RTL
==================

# fp_to_int_seq

Multi-cycle, parametrised IEEE-754 float-to-integer converter for the FPU datapath, feeding the integer register write-back path for `cvt.w.s`-class instructions. Accepts any binary floating-point format (exponent/fraction widths as parameters) and produces a signed or unsigned OUT_W-bit integer. Supports four rounding modes, saturation with IEEE-style status flags, and valid/ready handshakes on both sides. Alignment uses an iterative shifter of configurable step, so area can be traded against latency.

## Interface
- EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1
- FRAC_W, 23, fraction field width
- OUT_W, 32, integer result width (≥ 2)
- SHIFT_STEP, 8, maximum bit positions shifted per SHIFT cycle (≥ 1)
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input operand valid
- in_ready  out  1  converter can accept; high exactly when state is IDLE
- in_data  in  1+EXP_W+FRAC_W  {sign, exponent, fraction}
- is_signed  in  1  1: two's-complement result; 0: unsigned result; sampled at accept
- round_mode  in  2  00 toward zero, 01 nearest-even, 10 floor (−∞), 11 ceil (+∞); sampled at accept
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- out_data  out  OUT_W  integer result
- overflow  out  1  value above the maximum representable; result saturated high
- underflow  out  1  value below the minimum representable; result saturated low
- invalid  out  1  NaN input
- inexact  out  1  nonzero bits discarded by rounding (non-saturated results only)

## Operation
- States: IDLE, SHIFT, ROUND, DONE.
- Accept (IDLE, in_valid): latch sign, mode, and mantissa m = {hidden, fraction}; hidden = (exp≠0). Unbiased e = exp − bias for normals, 1 − bias for denormals.
- Specials, IDLE→DONE directly:
  - exp all-ones with frac≠0: out 0, invalid=1.
  - exp all-ones with frac=0, or e ≥ OUT_W: saturate.
  - Exact zero: out 0, no flags.
- Otherwise, load the work register W = {m, guard=0, sticky=0}:
  - e ≤ FRAC_W: right shift by r = min(FRAC_W − e, FRAC_W+2). Shifted-out bits pass through guard; everything below guard ORs into sticky.
  - e > FRAC_W: left shift by e − FRAC_W.
  - Shift amount 0 → ROUND; else → SHIFT.
- SHIFT: each cycle moves min(remaining, SHIFT_STEP) bits; → ROUND when remaining reaches 0.
- ROUND: compute increment inc.
  - RNE: G & (S | lsb).
  - Floor: neg & (G|S).
  - Ceil: ~neg & (G|S).
  - Trunc: 0.
  - mag = W_int + inc, evaluated at OUT_W+1 bits.
- Range check on mag:
  - Signed: overflow if ~neg and mag > 2^(OUT_W-1)−1; underflow if neg and mag > 2^(OUT_W-1).
  - Unsigned: overflow if ~neg and mag > 2^OUT_W−1; underflow if neg and mag ≠ 0.
- Saturation values:
  - Signed: high 0x7F..F, low 0x80..0.
  - Unsigned: high all-ones, low 0.
- Non-saturated result: out = neg ? −mag : mag; inexact = G|S. Then → DONE.
- DONE: out_valid=1; out_data and flags held stable. On out_ready → IDLE.
- Flags are exclusive: at most one of overflow, underflow, invalid is set. inexact=0 whenever any of them is set.

## Timing
- Reset (async assert, sync release): state IDLE, out_valid 0, out_data 0, all flags 0; in_ready 1.
- Reset mid-operation aborts immediately; no partial result is ever presented.
- Accept on the edge with in_valid & in_ready; in_ready drops the next cycle.
- Latency from accept edge to out_valid high:
  - Specials: 1 cycle.
  - Zero-shift: 2 cycles.
  - Otherwise: 2 + ceil(shift/SHIFT_STEP) cycles.
- Output transfer on the edge with out_valid & out_ready. in_ready is high the following cycle; there is no same-cycle re-accept.
- in_valid, in_data, and mode inputs are ignored outside IDLE.
- out_ready is don't-care outside DONE.
- Under backpressure, outputs stay constant for any number of cycles.

## Test plan
- 0x40490FDB (≈3.14159), RNE, signed, SHIFT_STEP=8 → out 3, inexact=1. Right shift 22 takes 3 SHIFT cycles; out_valid high 5 cycles after accept.
- Rounding on ±2.5 and 3.5 (0x40200000, 0xC0200000, 0x40600000), all four modes:
  - RNE: 2, −2, 4.
  - Trunc: 2, −2, 3.
  - Floor: 2, −3, 3.
  - Ceil: 3, −2, 4.
  - inexact=1 in every case.
- Range edges:
  - 0x4F000000 (2^31) signed → 0x7FFFFFFF, overflow.
  - Same value unsigned → 0x80000000, no flags.
  - 0xCF000000 signed → 0x80000000, no flags.
  - 0x00000001 ceil → 1, inexact.
- Specials:
  - 0x7FC00000 → 0, invalid, latency 1.
  - 0xFF800000 signed → 0x80000000, underflow.
  - 0xBF800000 (−1.0) unsigned → 0, underflow.
- Backpressure: hold out_ready low 10 cycles while pulsing in_valid with a new operand. out_data and flags stay constant, in_ready stays 0, and the new operand is not accepted until the cycle after transfer.
- Reset mid-SHIFT: out_valid 0, flags 0, in_ready 1 immediately. A subsequent 1.0 (0x3F800000) yields 1 with no flags.

Source files
------------

// File: rtl/fp_to_int_seq_if.sv
// Handshake bundle for the float-to-integer converter: operand in, result plus status out.
// master drives operands and takes results; slave is the converter.
`timescale 1ns/1ps
interface fp_to_int_seq_if #(
  parameter int EXP_W = 8,
  parameter int FRAC_W = 23,
  parameter int OUT_W = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [EXP_W+FRAC_W:0]   in_data;
  logic                    is_signed;
  logic [1:0]              round_mode;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        out_data;
  logic                    overflow;
  logic                    underflow;
  logic                    invalid;
  logic                    inexact;

  modport master (
    output in_valid, in_data, is_signed, round_mode, out_ready,
    input  in_ready, out_valid, out_data, overflow, underflow, invalid, inexact
  );

  modport slave (
    input  in_valid, in_data, is_signed, round_mode, out_ready,
    output in_ready, out_valid, out_data, overflow, underflow, invalid, inexact
  );
endinterface

// File: rtl/fp_to_int_seq.sv
// Iterative IEEE float to signed/unsigned integer converter, 4 rounding modes, saturating flags.
// Latency 1 (specials), 2 (no shift) or 2+ceil(shift/SHIFT_STEP); one op in flight, result held until out_ready.
`timescale 1ns/1ps
module fp_to_int_seq #(
  parameter int EXP_W      = 8,
  parameter int FRAC_W     = 23,
  parameter int OUT_W      = 32,
  parameter int SHIFT_STEP = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  fp_to_int_seq_if.slave io
);
  localparam int BIAS    = (1 << (EXP_W - 1)) - 1;
  localparam int MW      = FRAC_W + 1;
  localparam int IW      = (MW > OUT_W) ? MW : OUT_W;
  localparam int MAXSH_A = (FRAC_W + 2 > OUT_W) ? FRAC_W + 2 : OUT_W;
  localparam int MAXSH   = (MAXSH_A > SHIFT_STEP) ? MAXSH_A : SHIFT_STEP;
  localparam int SW      = $clog2(MAXSH + 1);

  localparam logic [OUT_W:0] SMAX  = {2'b00, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W:0] SMINM = {2'b01, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     wint_q, wint_d;
  logic              g_q, g_d, s_q, s_d;
  logic [SW-1:0]     rem_q, rem_d;
  logic              left_q, left_d;
  logic              neg_q, neg_d, sgn_q, sgn_d;
  logic [1:0]        rm_q, rm_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d, inx_q, inx_d;

  logic [EXP_W-1:0]  exp_v;
  logic [FRAC_W-1:0] frac_v;
  logic [MW-1:0]     mant_v;
  int                e_v, sh_v;
  logic [SW-1:0]     step_v;
  logic [IW:0]       x_v, mask_v;
  logic              inc_v, ovf_c, unf_c;
  logic [OUT_W:0]    mag_v;

  function automatic logic [OUT_W-1:0] sat_val(input logic neg, input logic sgn);
    if (sgn) return neg ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    return neg ? {OUT_W{1'b0}} : {OUT_W{1'b1}};
  endfunction

  always_comb begin
    state_d = state_q;
    wint_d  = wint_q;
    g_d     = g_q;
    s_d     = s_q;
    rem_d   = rem_q;
    left_d  = left_q;
    neg_d   = neg_q;
    sgn_d   = sgn_q;
    rm_d    = rm_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    inv_d   = inv_q;
    inx_d   = inx_q;
    exp_v   = io.in_data[FRAC_W +: EXP_W];
    frac_v  = io.in_data[FRAC_W-1:0];
    mant_v  = {|exp_v, frac_v};
    e_v     = (exp_v != '0) ? int'(exp_v) - BIAS : 1 - BIAS;
    sh_v    = 0;
    step_v  = (rem_q > SW'(SHIFT_STEP)) ? SW'(SHIFT_STEP) : rem_q;
    x_v     = {wint_q, g_q};
    mask_v  = ~({(IW+1){1'b1}} << step_v);
    inc_v   = 1'b0;
    mag_v   = '0;
    ovf_c   = 1'b0;
    unf_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          neg_d = io.in_data[EXP_W+FRAC_W];
          sgn_d = io.is_signed;
          rm_d  = io.round_mode;
          out_d = '0;
          ovf_d = 1'b0;
          unf_d = 1'b0;
          inv_d = 1'b0;
          inx_d = 1'b0;
          if ((&exp_v) && (|frac_v)) begin
            inv_d   = 1'b1;
            state_d = DONE;
          end else if ((&exp_v) || e_v >= OUT_W) begin
            out_d   = sat_val(io.in_data[EXP_W+FRAC_W], io.is_signed);
            ovf_d   = ~io.in_data[EXP_W+FRAC_W];
            unf_d   = io.in_data[EXP_W+FRAC_W];
            state_d = DONE;
          end else if (exp_v == '0 && frac_v == '0) begin
            state_d = DONE;
          end else begin
            // Right shifts past guard+sticky are clamped: everything lands in sticky anyway.
            if (e_v <= FRAC_W) begin
              sh_v   = FRAC_W - e_v;
              if (sh_v > FRAC_W + 2) sh_v = FRAC_W + 2;
              left_d = 1'b0;
            end else begin
              sh_v   = e_v - FRAC_W;
              left_d = 1'b1;
            end
            wint_d  = IW'(mant_v);
            g_d     = 1'b0;
            s_d     = 1'b0;
            rem_d   = SW'(sh_v);
            state_d = (sh_v == 0) ? ROUND : SHIFT;
          end
        end
      end
      SHIFT: begin
        if (left_q) begin
          wint_d = wint_q << step_v;
        end else begin
          {wint_d, g_d} = x_v >> step_v;
          s_d           = s_q | (|(x_v & mask_v));
        end
        rem_d = rem_q - step_v;
        if (rem_q == step_v) state_d = ROUND;
      end
      ROUND: begin
        unique case (rm_q)
          2'b01:   inc_v = g_q & (s_q | wint_q[0]);
          2'b10:   inc_v = neg_q & (g_q | s_q);
          2'b11:   inc_v = ~neg_q & (g_q | s_q);
          default: inc_v = 1'b0;
        endcase
        mag_v = {1'b0, wint_q[OUT_W-1:0]} + {{OUT_W{1'b0}}, inc_v};
        if (sgn_q) begin
          ovf_c = ~neg_q & (mag_v > SMAX);
          unf_c = neg_q & (mag_v > SMINM);
        end else begin
          ovf_c = ~neg_q & mag_v[OUT_W];
          unf_c = neg_q & (mag_v != '0);
        end
        if (ovf_c || unf_c) begin
          out_d = sat_val(neg_q, sgn_q);
          ovf_d = ovf_c;
          unf_d = unf_c;
          inx_d = 1'b0;
        end else begin
          out_d = neg_q ? -mag_v[OUT_W-1:0] : mag_v[OUT_W-1:0];
          inx_d = g_q | s_q;
        end
        state_d = DONE;
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wint_q  <= '0;
      g_q     <= 1'b0;
      s_q     <= 1'b0;
      rem_q   <= '0;
      left_q  <= 1'b0;
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
      rm_q    <= 2'b00;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      inv_q   <= 1'b0;
      inx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wint_q  <= wint_d;
      g_q     <= g_d;
      s_q     <= s_d;
      rem_q   <= rem_d;
      left_q  <= left_d;
      neg_q   <= neg_d;
      sgn_q   <= sgn_d;
      rm_q    <= rm_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      inv_q   <= inv_d;
      inx_q   <= inx_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.out_data  = out_q;
  assign io.overflow  = ovf_q;
  assign io.underflow = unf_q;
  assign io.invalid   = inv_q;
  assign io.inexact   = inx_q;
endmodule
